sys_mem_part_ptr_mngr: RTL



---
 rtl/sys_mem_part_ptr_mngr.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/sys_mem_part_ptr_mngr.sv
// sys_mem_part_ptr_mngr
//   Per-agent running address pointer for system memory partitions. A burst
//   request (agent, length) is turned into one or more memory commands that
//   stay inside the agent's partition [start, end]. A burst that runs past the
//   end is split and continued from start, as often as needed.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   agent_id          partition table read index (registered, held per request)
//   mem_start_addr    partition start, valid LOOKUP_LAT cycles after agent_id
//   mem_end_addr      partition end (inclusive); end < start means single word
//   part_sync         pulse: table reprogrammed, invalidate all pointers
//   req_*             burst request handshake (req_len = 0 is accepted, no cmd)
//   cmd_*             memory command handshake; cmd_len >= 1, cmd_last on the
//                     final command of a request
module sys_mem_part_ptr_mngr #(
  parameter int MEM_ADDR_W = 27,
  parameter int NUM_AGENTS = 2,
  parameter int LEN_W      = 8,
  parameter int LOOKUP_LAT = 2,
  parameter int AGENT_ID_W = $clog2(NUM_AGENTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [AGENT_ID_W-1:0] agent_id,
  input  logic [MEM_ADDR_W-1:0] mem_start_addr,
  input  logic [MEM_ADDR_W-1:0] mem_end_addr,
  input  logic                  part_sync,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AGENT_ID_W-1:0] req_agent_id,
  input  logic [LEN_W-1:0]      req_len,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [MEM_ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]      cmd_len,
  output logic [AGENT_ID_W-1:0] cmd_agent_id,
  output logic                  cmd_last
);

  localparam int CNT_W = $clog2(LOOKUP_LAT + 2);

  typedef enum logic [1:0] {IDLE, LOOKUP, SETUP, ISSUE} state_e;

  state_e                                  state_q, state_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic [AGENT_ID_W-1:0]                   aid_q, aid_d;
  logic [LEN_W-1:0]                        rem_q, rem_d;
  logic [MEM_ADDR_W-1:0]                   s_q, s_d, e_q, e_d;
  logic [MEM_ADDR_W-1:0]                   cur_q, cur_d;
  logic                                    pvld_q, pvld_d;
  logic [NUM_AGENTS-1:0][MEM_ADDR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_AGENTS-1:0]                   vld_q, vld_d;
  logic                                    req_ready_q, req_ready_d;
  logic                                    cmd_valid_q, cmd_valid_d;
  logic [MEM_ADDR_W-1:0]                   cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]                        cmd_len_q, cmd_len_d;
  logic                                    cmd_last_q, cmd_last_d;

  logic [MEM_ADDR_W:0]                     nxt;
  logic [MEM_ADDR_W-1:0]                   p_sel;
  logic [LEN_W-1:0]                        seg, rem_n;

  // min(r, e-p+1); p is always within [s, e] so the span is at least 1.
  function automatic logic [LEN_W-1:0] seg_len(input logic [MEM_ADDR_W-1:0] p,
                                               input logic [MEM_ADDR_W-1:0] e,
                                               input logic [LEN_W-1:0]      r);
    logic [MEM_ADDR_W:0] span, rx;
    span = {1'b0, e} - {1'b0, p} + 1'b1;
    rx   = (MEM_ADDR_W+1)'(r);
    return (rx <= span) ? r : LEN_W'(span);
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    aid_d       = aid_q;
    rem_d       = rem_q;
    s_d         = s_q;
    e_d         = e_q;
    cur_d       = cur_q;
    pvld_d      = pvld_q;
    ptr_d       = ptr_q;
    vld_d       = vld_q;
    req_ready_d = req_ready_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    cmd_last_d  = cmd_last_q;
    nxt         = '0;
    p_sel       = '0;
    seg         = '0;
    rem_n       = '0;

    // Clear first so pointer writes of an in-flight request below win.
    if (part_sync) vld_d = '0;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q && (req_len != '0)) begin
          aid_d       = req_agent_id;
          rem_d       = req_len;
          cnt_d       = '0;
          // Snapshot the pointer now so a later part_sync only hits the
          // next request, not this one.
          cur_d       = ptr_q[req_agent_id];
          pvld_d      = vld_q[req_agent_id] & ~part_sync;
          req_ready_d = 1'b0;
          state_d     = LOOKUP;
        end
      end

      LOOKUP: begin
        if (cnt_q == CNT_W'(LOOKUP_LAT)) begin
          s_d     = mem_start_addr;
          e_d     = (mem_end_addr < mem_start_addr) ? mem_start_addr : mem_end_addr;
          state_d = SETUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SETUP: begin
        p_sel          = (pvld_q && (cur_q >= s_q) && (cur_q <= e_q)) ? cur_q : s_q;
        seg            = seg_len(p_sel, e_q, rem_q);
        cur_d          = p_sel;
        ptr_d[aid_q]   = p_sel;
        vld_d[aid_q]   = 1'b1;
        cmd_valid_d    = 1'b1;
        cmd_addr_d     = p_sel;
        cmd_len_d      = seg;
        cmd_last_d     = (seg == rem_q);
        state_d        = ISSUE;
      end

      ISSUE: begin
        if (cmd_valid_q && cmd_ready) begin
          // Widened add: ptr+len can exceed the top of the address space.
          nxt          = {1'b0, cur_q} + (MEM_ADDR_W+1)'(cmd_len_q);
          p_sel        = (nxt > {1'b0, e_q}) ? s_q : nxt[MEM_ADDR_W-1:0];
          rem_n        = rem_q - cmd_len_q;
          rem_d        = rem_n;
          cur_d        = p_sel;
          ptr_d[aid_q] = p_sel;
          vld_d[aid_q] = 1'b1;
          if (rem_n == '0) begin
            cmd_valid_d = 1'b0;
            cmd_last_d  = 1'b0;
            req_ready_d = 1'b1;
            state_d     = IDLE;
          end else begin
            seg        = seg_len(p_sel, e_q, rem_n);
            cmd_addr_d = p_sel;
            cmd_len_d  = seg;
            cmd_last_d = (seg == rem_n);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      aid_q       <= '0;
      rem_q       <= '0;
      s_q         <= '0;
      e_q         <= '0;
      cur_q       <= '0;
      pvld_q      <= 1'b0;
      ptr_q       <= '0;
      vld_q       <= '0;
      req_ready_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      cmd_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      aid_q       <= aid_d;
      rem_q       <= rem_d;
      s_q         <= s_d;
      e_q         <= e_d;
      cur_q       <= cur_d;
      pvld_q      <= pvld_d;
      ptr_q       <= ptr_d;
      vld_q       <= vld_d;
      req_ready_q <= req_ready_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      cmd_last_q  <= cmd_last_d;
    end
  end

  assign agent_id     = aid_q;
  assign cmd_agent_id = aid_q;
  assign req_ready    = req_ready_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_addr     = cmd_addr_q;
  assign cmd_len      = cmd_len_q;
  assign cmd_last     = cmd_last_q;

endmodule
